// File: rtl/cp0_tlb_pkg.sv
// Shared TLB command codes, EntryHi/EntryLo field positions, entry record and FSM states.
package cp0_tlb_pkg;

  localparam logic [1:0] TLB_OP_TLBR  = 2'd0;
  localparam logic [1:0] TLB_OP_TLBWI = 2'd1;
  localparam logic [1:0] TLB_OP_TLBWR = 2'd2;
  localparam logic [1:0] TLB_OP_TLBP  = 2'd3;

  localparam int HI_VPN2_LSB = 13;
  localparam int HI_VPN2_W   = 19;
  localparam int HI_ASID_LSB = 0;
  localparam int HI_ASID_W   = 8;
  localparam int LO_G_BIT    = 0;
  localparam int LO_CDV_LSB  = 1;
  localparam int LO_CDV_W    = 5;
  localparam int LO_PFN_LSB  = 6;
  // Widest PFN that still fits in a 32-bit EntryLo; narrower builds leave the top bits zero.
  localparam int PFN_MAX_W   = 26;

  typedef struct packed {
    logic [HI_VPN2_W-1:0] vpn2;
    logic [HI_ASID_W-1:0] asid;
    logic                 g;
    logic [PFN_MAX_W-1:0] pfn0;
    logic [LO_CDV_W-1:0]  cdv0;
    logic [PFN_MAX_W-1:0] pfn1;
    logic [LO_CDV_W-1:0]  cdv1;
  } tlb_entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } tlb_state_t;

endpackage

// File: rtl/cp0_tlb_match.sv
// Combinational single-entry TLBP comparator: VPN2 equal and (global or ASID equal).
module cp0_tlb_match
  import cp0_tlb_pkg::*;
(
  input  logic [31:0] hi,
  input  tlb_entry_t  entry,
  output logic        hit
);

  logic unused_bits;

  assign hit = (hi[HI_VPN2_LSB +: HI_VPN2_W] == entry.vpn2) &&
               (entry.g || (hi[HI_ASID_LSB +: HI_ASID_W] == entry.asid));

  assign unused_bits = ^{hi[12:8], entry.pfn0, entry.cdv0, entry.pfn1, entry.cdv1};

endmodule

// File: rtl/cp0_tlb_array.sv
// CP0 TLB entry store with TLBR/TLBWI/TLBWR/TLBP and the Random register.
// Define CP0_TLB_PARALLEL_PROBE_EN for a single-cycle parallel probe instead of the sequential scan.
module cp0_tlb_array
  import cp0_tlb_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int PFN_W   = 20,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  output logic             cmd_ready,
  input  logic [IDX_W-1:0] index,
  input  logic [IDX_W-1:0] wired,
  input  logic [31:0]      hi_in,
  input  logic [31:0]      lo0_in,
  input  logic [31:0]      lo1_in,
  output logic             done,
  output logic [31:0]      hi_out,
  output logic [31:0]      lo0_out,
  output logic [31:0]      lo1_out,
  output logic             probe_miss,
  output logic [IDX_W-1:0] probe_idx,
  output logic [IDX_W-1:0] random
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(ENTRIES - 1);

  tlb_entry_t       entries [ENTRIES];
  tlb_state_t       state_reg, state_next;
  logic [IDX_W-1:0] wired_reg;
  tlb_entry_t       new_entry, rd_e;
  logic [31:0]      rd_lo0, rd_lo1;
  logic             accept;
  logic             unused_bits;

  assign cmd_ready = (state_reg == ST_IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign rd_e      = entries[index];

  always_comb begin
    new_entry      = '0;
    new_entry.vpn2 = hi_in[HI_VPN2_LSB +: HI_VPN2_W];
    new_entry.asid = hi_in[HI_ASID_LSB +: HI_ASID_W];
    new_entry.g    = lo0_in[LO_G_BIT] & lo1_in[LO_G_BIT];
    new_entry.pfn0[PFN_W-1:0] = lo0_in[LO_PFN_LSB +: PFN_W];
    new_entry.cdv0 = lo0_in[LO_CDV_LSB +: LO_CDV_W];
    new_entry.pfn1[PFN_W-1:0] = lo1_in[LO_PFN_LSB +: PFN_W];
    new_entry.cdv1 = lo1_in[LO_CDV_LSB +: LO_CDV_W];
  end

  // G is kept once per entry, so both read-back pages report the combined bit.
  always_comb begin
    rd_lo0 = '0;
    rd_lo0[LO_PFN_LSB +: PFN_W]    = rd_e.pfn0[PFN_W-1:0];
    rd_lo0[LO_CDV_LSB +: LO_CDV_W] = rd_e.cdv0;
    rd_lo0[LO_G_BIT]               = rd_e.g;
    rd_lo1 = '0;
    rd_lo1[LO_PFN_LSB +: PFN_W]    = rd_e.pfn1[PFN_W-1:0];
    rd_lo1[LO_CDV_LSB +: LO_CDV_W] = rd_e.cdv1;
    rd_lo1[LO_G_BIT]               = rd_e.g;
  end

  assign unused_bits = ^{hi_in[12:8], lo0_in >> (PFN_W + 6), lo1_in >> (PFN_W + 6),
                         rd_e.pfn0 >> PFN_W, rd_e.pfn1 >> PFN_W};

`ifdef CP0_TLB_PARALLEL_PROBE_EN
  logic [ENTRIES-1:0] hits;
  logic [IDX_W-1:0]   par_idx;

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_match
      cp0_tlb_match u_match (.hi(hi_in), .entry(entries[gi]), .hit(hits[gi]));
    end
  endgenerate

  always_comb begin
    par_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (hits[i]) par_idx = IDX_W'(i);
    end
  end
`else
  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W-1:0] cmp_idx;
  logic             seq_hit;

  // Entry 0 is compared in the accept cycle, so entry k's result lands with done in cycle k+1.
  assign cmp_idx = (state_reg == ST_SCAN) ? ptr_reg : '0;

  cp0_tlb_match u_match (.hi(hi_in), .entry(entries[cmp_idx]), .hit(seq_hit));
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
`ifndef CP0_TLB_PARALLEL_PROBE_EN
        if (accept && cmd_op == TLB_OP_TLBP) state_next = ST_SCAN;
`endif
      end
      ST_SCAN: if (done) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      done       <= 1'b0;
      hi_out     <= '0;
      lo0_out    <= '0;
      lo1_out    <= '0;
      probe_miss <= 1'b0;
      probe_idx  <= '0;
`ifndef CP0_TLB_PARALLEL_PROBE_EN
      ptr_reg    <= '0;
`endif
      for (int i = 0; i < ENTRIES; i++) entries[i] <= '0;
    end else begin
      state_reg <= state_next;
      done      <= 1'b0;
      if (accept) begin
        case (cmd_op)
          TLB_OP_TLBR: begin
            hi_out  <= {rd_e.vpn2, 5'b0, rd_e.asid};
            lo0_out <= rd_lo0;
            lo1_out <= rd_lo1;
            done    <= 1'b1;
          end
          TLB_OP_TLBWI: begin
            entries[index] <= new_entry;
            done           <= 1'b1;
          end
          TLB_OP_TLBWR: begin
            entries[random] <= new_entry;
            done            <= 1'b1;
          end
          default: begin
`ifdef CP0_TLB_PARALLEL_PROBE_EN
            probe_miss <= ~|hits;
            if (|hits) probe_idx <= par_idx;
            done <= 1'b1;
`else
            ptr_reg <= IDX_W'(1);
            if (seq_hit) begin
              probe_miss <= 1'b0;
              probe_idx  <= '0;
              done       <= 1'b1;
            end
`endif
          end
        endcase
      end
`ifndef CP0_TLB_PARALLEL_PROBE_EN
      else if (state_reg == ST_SCAN && !done) begin
        if (seq_hit) begin
          probe_miss <= 1'b0;
          probe_idx  <= ptr_reg;
          done       <= 1'b1;
        end else if (ptr_reg == LAST) begin
          probe_miss <= 1'b1;
          done       <= 1'b1;
        end
        ptr_reg <= ptr_reg + 1'b1;
      end
`endif
    end
  end

  // Random walks down from ENTRIES-1 to wired, then wraps; any Wired change restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      random    <= LAST;
      wired_reg <= '0;
    end else begin
      wired_reg <= wired;
      if (wired != wired_reg || wired == LAST || random == wired || random == '0)
        random <= LAST;
      else
        random <= random - 1'b1;
    end
  end

endmodule
